// File: rtl/izh_neuron_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : izh_neuron_scheduler_if
// Brief    : Request/acknowledge link between the neuron scheduler and the
//            shared Izhikevich update datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface izh_neuron_scheduler_if;
    logic        dp_req;
    logic [17:0] dp_v;
    logic [17:0] dp_u;
    logic [3:0]  dp_type;
    logic [7:0]  dp_cur;
    logic        dp_ack;
    logic [17:0] dp_v_new;
    logic [17:0] dp_u_new;
    logic        dp_spike;

    modport master (
        output dp_req, dp_v, dp_u, dp_type, dp_cur,
        input  dp_ack, dp_v_new, dp_u_new, dp_spike
    );

    modport slave (
        input  dp_req, dp_v, dp_u, dp_type, dp_cur,
        output dp_ack, dp_v_new, dp_u_new, dp_spike
    );
endinterface
`default_nettype wire

// File: rtl/izh_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : izh_neuron_scheduler
// Brief    : Sweeps NUM_NEURONS virtual neurons through one shared update
//            datapath per tick, holding per-neuron v/u state and config.
// Options  : SPIKE_COUNT_EN adds an 8-bit saturating per-sweep spike_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module izh_neuron_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int IDX_W       = 2,
    parameter int DP_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_addr,
    input  logic [3:0]            cfg_type,
    input  logic [7:0]            cfg_cur,
    izh_neuron_scheduler_if.master dp,
    output logic                  spike_valid,
    output logic [IDX_W-1:0]      spike_idx,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    output logic                  overrun,
    output logic                  dp_err,
    input  logic [IDX_W-1:0]      mon_sel,
    output logic [7:0]            mon_v
`ifdef SPIKE_COUNT_EN
    ,
    output logic [7:0]            spike_cnt
`endif
);

    localparam logic [17:0]          c_v_rst    = 18'h34CCD;
    localparam logic [17:0]          c_u_rst    = 18'h3CCCD;
    localparam int                   c_tmo_w    = $clog2(DP_TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_last = c_tmo_w'(DP_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     c_idx_last = IDX_W'(NUM_NEURONS - 1);
    localparam logic [IDX_W:0]       c_num      = (IDX_W + 1)'(NUM_NEURONS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_timeout;

    logic [17:0]          r_v    [NUM_NEURONS];
    logic [17:0]          r_u    [NUM_NEURONS];
    logic [3:0]           r_type [NUM_NEURONS];
    logic [7:0]           r_cur  [NUM_NEURONS];

    logic [IDX_W-1:0]     r_idx;
    logic [c_tmo_w-1:0]   r_tmo_cnt;
    logic [17:0]          r_dp_v;
    logic [17:0]          r_dp_u;
    logic [3:0]           r_dp_type;
    logic [7:0]           r_dp_cur;
    logic [17:0]          r_v_new;
    logic [17:0]          r_u_new;
    logic                 r_spike;
    logic                 r_wr_en;
    logic                 r_overrun;
    logic                 r_dp_err;

    logic                 w_cfg_hit;
    logic                 w_mon_ok;

    assign w_cfg_hit = cfg_we && ({1'b0, cfg_addr} < c_num);
    assign w_mon_ok  = ({1'b0, mon_sel} < c_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tick) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (dp.dp_ack) begin
                    w_state_nxt = S_WRITE;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = (r_idx == c_idx_last) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_tmo_cnt <= '0;
            r_dp_v    <= '0;
            r_dp_u    <= '0;
            r_dp_type <= '0;
            r_dp_cur  <= '0;
            r_v_new   <= '0;
            r_u_new   <= '0;
            r_spike   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_overrun <= 1'b0;
            r_dp_err  <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_v[i]    <= c_v_rst;
                r_u[i]    <= c_u_rst;
                r_type[i] <= '0;
                r_cur[i]  <= '0;
            end
        end else begin
            if (tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (tick) begin
                        r_idx <= '0;
                    end
                end
                S_ISSUE: begin
                    r_dp_v    <= r_v[r_idx];
                    r_dp_u    <= r_u[r_idx];
                    r_dp_type <= r_type[r_idx];
                    r_dp_cur  <= r_cur[r_idx];
                    r_tmo_cnt <= '0;
                    r_wr_en   <= 1'b0;
                    r_spike   <= 1'b0;
                end
                S_WAIT: begin
                    if (dp.dp_ack) begin
                        r_v_new <= dp.dp_v_new;
                        r_u_new <= dp.dp_u_new;
                        r_spike <= dp.dp_spike;
                        r_wr_en <= 1'b1;
                    end else if (w_timeout) begin
                        r_dp_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
                    end
                end
                S_WRITE: begin
                    if (r_wr_en) begin
                        r_v[r_idx] <= r_v_new;
                        r_u[r_idx] <= r_u_new;
                    end
                    if (r_idx != c_idx_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
            // Config lands in the slot only; the in-flight copy in r_dp_* is untouched.
            if (w_cfg_hit) begin
                r_type[cfg_addr] <= cfg_type;
                r_cur[cfg_addr]  <= cfg_cur;
            end
        end
    end

    assign dp.dp_req  = (r_state == S_WAIT);
    assign dp.dp_v    = r_dp_v;
    assign dp.dp_u    = r_dp_u;
    assign dp.dp_type = r_dp_type;
    assign dp.dp_cur  = r_dp_cur;

    assign spike_valid = (r_state == S_WRITE) && r_spike;
    assign spike_idx   = spike_valid ? r_idx : '0;
    assign sweep_busy  = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);
    assign sweep_done  = (r_state == S_DONE);
    assign overrun     = r_overrun;
    assign dp_err      = r_dp_err;
    assign mon_v       = w_mon_ok ? r_v[mon_sel][17:10] : 8'h00;

`ifdef SPIKE_COUNT_EN
    logic [7:0] r_spike_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_cnt <= '0;
        end else if ((r_state == S_ISSUE) && (r_idx == '0)) begin
            r_spike_cnt <= '0;
        end else if (spike_valid && (r_spike_cnt != 8'hFF)) begin
            r_spike_cnt <= r_spike_cnt + 8'd1;
        end
    end

    assign spike_cnt = r_spike_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_izh_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_izh_neuron_scheduler
// Brief    : Self-checking bench: vector table, hand corner sequences and
//            randomized sweeps against a per-neuron reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_izh_neuron_scheduler;

    localparam int N     = 4;
    localparam int DP_TO = 15;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_type;
    logic [7:0] cfg_cur;
    logic [1:0] mon_sel;
    logic       spike_valid;
    logic [1:0] spike_idx;
    logic       sweep_busy;
    logic       sweep_done;
    logic       overrun;
    logic       dp_err;
    logic [7:0] mon_v;
`ifdef SPIKE_COUNT_EN
    logic [7:0] spike_cnt;
`endif

    izh_neuron_scheduler_if dp_if ();

    izh_neuron_scheduler #(
        .NUM_NEURONS (N),
        .IDX_W       (2),
        .DP_TIMEOUT  (DP_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_type    (cfg_type),
        .cfg_cur     (cfg_cur),
        .dp          (dp_if),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .overrun     (overrun),
        .dp_err      (dp_err),
        .mon_sel     (mon_sel),
        .mon_v       (mon_v)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_cnt   (spike_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the architectural state
    logic [17:0] m_v [N];
    logic [17:0] m_u [N];
    logic [3:0]  m_type [N];
    logic [7:0]  m_cur [N];
    bit          m_err;
    bit          m_ovr;

    // Datapath responder configuration (lat < 0 means never ack)
    int          lat_cfg [16];
    logic [15:0] spk_cfg;
    logic [17:0] dv_cfg;
    logic [17:0] du_cfg;

    // Responder-owned handshake log
    logic [17:0] log_v [16];
    logic [17:0] log_u [16];
    logic [3:0]  log_t [16];
    logic [7:0]  log_c [16];
    int          log_n;
    int          stab_bad;

    typedef struct {
        bit          cfg_en;
        int          cfg_a;
        logic [3:0]  cfg_t;
        logic [7:0]  cfg_c;
        int          l0, l1, l2, l3;
        logic [3:0]  spk;
        logic [17:0] dv, du;
        int          exp_cyc;
        int          exp_nspk;
    } vec_t;

    vec_t tab [4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k]    = 18'h34CCD;
            m_u[k]    = 18'h3CCCD;
            m_type[k] = 4'd0;
            m_cur[k]  = 8'd0;
        end
        m_err = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic check_mon_all(input string tag);
        for (int k = 0; k < N; k++) begin
            mon_sel = 2'(k);
            #1;
            check($sformatf("%s_mon_v%0d", tag, k), mon_v, m_v[k][17:10]);
        end
    endtask

    task automatic cfg_write(input int a, input logic [3:0] t, input logic [7:0] c);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 2'(a);
        cfg_type = t;
        cfg_cur  = c;
        @(negedge clk);
        cfg_we   = 1'b0;
        m_type[a] = t;
        m_cur[a]  = c;
    endtask

    // Datapath model: acks lat cycles into the request, returns v+dv / u+du.
    initial begin
        int wcnt;
        int cur_req;
        int req_num;
        bit in_req;
        dp_if.dp_ack    = 1'b0;
        dp_if.dp_v_new  = '0;
        dp_if.dp_u_new  = '0;
        dp_if.dp_spike  = 1'b0;
        wcnt = 0; cur_req = 0; req_num = 0; in_req = 1'b0;
        log_n = 0; stab_bad = 0;
        forever begin
            @(negedge clk);
            if (!sweep_busy) req_num = 0;
            if (!dp_if.dp_req) begin
                dp_if.dp_ack   = 1'b0;
                dp_if.dp_spike = 1'b0;
                in_req         = 1'b0;
            end else begin
                if (!in_req) begin
                    in_req  = 1'b1;
                    wcnt    = 0;
                    cur_req = req_num & 15;
                    req_num++;
                    log_n   = req_num;
                    log_v[cur_req] = dp_if.dp_v;
                    log_u[cur_req] = dp_if.dp_u;
                    log_t[cur_req] = dp_if.dp_type;
                    log_c[cur_req] = dp_if.dp_cur;
                end else if ({dp_if.dp_v, dp_if.dp_u, dp_if.dp_type, dp_if.dp_cur} !==
                             {log_v[cur_req], log_u[cur_req], log_t[cur_req], log_c[cur_req]}) begin
                    stab_bad++;
                end
                if (!dp_if.dp_ack && lat_cfg[cur_req] >= 0 && wcnt == lat_cfg[cur_req]) begin
                    dp_if.dp_ack   = 1'b1;
                    dp_if.dp_v_new = dp_if.dp_v + dv_cfg;
                    dp_if.dp_u_new = dp_if.dp_u + du_cfg;
                    dp_if.dp_spike = spk_cfg[cur_req];
                end
                wcnt++;
            end
        end
    end

    task automatic run_sweep(input int l0, input int l1, input int l2, input int l3,
                             input logic [3:0] spk, input logic [17:0] dv, input logic [17:0] du,
                             input int mon_slot, input int ecyc, input int enspk,
                             input bit mw_en, input int mw_addr,
                             input logic [3:0] mw_type, input logic [7:0] mw_cur);
        int          lat [4];
        logic [17:0] nv [4];
        logic [17:0] nu [4];
        int          exp_spk [$];
        int          got_spk [$];
        int          mcyc;
        int          cyc;
        int          wr_k;
        bit          prev_req;
        bit          mw_done;
        bit          is_write;
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
        for (int k = 0; k < 16; k++) lat_cfg[k] = (k < N) ? lat[k] : 0;
        spk_cfg = {12'd0, spk};
        dv_cfg  = dv;
        du_cfg  = du;

        // Expected outcome from the sweep rules: per neuron ISSUE + WAIT + WRITE, then DONE.
        mcyc = 1;
        for (int k = 0; k < N; k++) begin
            mcyc += 2 + ((lat[k] < 0) ? DP_TO : lat[k] + 1);
            if (lat[k] < 0) begin
                nv[k] = m_v[k];
                nu[k] = m_u[k];
                m_err = 1'b1;
            end else begin
                nv[k] = m_v[k] + dv;
                nu[k] = m_u[k] + du;
                if (spk[k]) exp_spk.push_back(k);
            end
        end
        if (ecyc < 0)  ecyc  = mcyc;
        if (enspk < 0) enspk = exp_spk.size();

        mon_sel = 2'(mon_slot);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc = 1; wr_k = 0; prev_req = 1'b0; mw_done = 1'b0;
        check("busy_first_cycle", sweep_busy, 1);
        while (!sweep_done && cyc < 200) begin
            cfg_we   = 1'b0;
            is_write = prev_req && !dp_if.dp_req;
            if (is_write && wr_k == mon_slot)
                check("mon_v_old_on_write", mon_v, m_v[mon_slot][17:10]);
            if (spike_valid) begin
                got_spk.push_back(int'(spike_idx));
                check("spike_in_write_slot", {31'd0, is_write} + (int'(spike_idx) == wr_k ? 2 : 0), 3);
            end
            if (is_write) wr_k++;
            if (mw_en && !mw_done && dp_if.dp_req && wr_k == mw_addr) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'(mw_addr);
                cfg_type = mw_type;
                cfg_cur  = mw_cur;
                mw_done  = 1'b1;
            end
            prev_req = dp_if.dp_req;
            @(negedge clk);
            cyc++;
        end
        cfg_we = 1'b0;
        check("sweep_cycles", cyc, ecyc);
        check("busy_low_in_done", sweep_busy, 0);
        check("spike_count", got_spk.size(), enspk);
        if (got_spk.size() == exp_spk.size())
            for (int i = 0; i < got_spk.size(); i++)
                check($sformatf("spike_idx_%0d", i), got_spk[i], exp_spk[i]);
        check("handshakes", log_n, N);
        for (int k = 0; k < N; k++) begin
            check($sformatf("issue%0d_v", k), log_v[k], m_v[k]);
            check($sformatf("issue%0d_u", k), log_u[k], m_u[k]);
            check($sformatf("issue%0d_type", k), log_t[k], m_type[k]);
            check($sformatf("issue%0d_cur", k), log_c[k], m_cur[k]);
        end
        for (int k = 0; k < N; k++) begin
            m_v[k] = nv[k];
            m_u[k] = nu[k];
        end
        if (mw_en) begin
            m_type[mw_addr] = mw_type;
            m_cur[mw_addr]  = mw_cur;
        end
        @(negedge clk);
        check("done_one_cycle", sweep_done, 0);
        check("dp_stable_while_req", stab_bad, 0);
        check("dp_err", dp_err, m_err);
        check("overrun", overrun, m_ovr);
`ifdef SPIKE_COUNT_EN
        check("spike_cnt", spike_cnt, (enspk > 255) ? 255 : enspk);
`endif
        check_mon_all("post");
    endtask

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 9));
        return (r == 0) ? -1 : (r % 4);
    endfunction

    initial begin
        int n_done;
        int k;
        int wr;
        bit prev;

        tab[0] = '{1'b0, 0, 4'd0, 8'h00, 0, 0, 0, 0, 4'b0000, 18'd1, 18'd2, 13, 0};
        tab[1] = '{1'b1, 2, 4'd3, 8'h0A, 0, 0, 0, 0, 4'b0010, 18'd1, 18'd1, 13, 1};
        tab[2] = '{1'b0, 0, 4'd0, 8'h00, 1, 0, 2, 0, 4'b1001, 18'h00400, 18'h3FFFF, 16, 2};
        tab[3] = '{1'b0, 0, 4'd0, 8'h00, -1, 0, 0, 0, 4'b0001, 18'd7, 18'd7, 27, 0};

        rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_type = '0; cfg_cur = '0; mon_sel = '0;
        for (int i = 0; i < 16; i++) lat_cfg[i] = 0;
        spk_cfg = '0; dv_cfg = '0; du_cfg = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_dp_req", dp_if.dp_req, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike_idx", spike_idx, 0);
        check("rst_sweep_busy", sweep_busy, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_dp_err", dp_err, 0);
`ifdef SPIKE_COUNT_EN
        check("rst_spike_cnt", spike_cnt, 0);
`endif
        check_mon_all("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 4; t++) begin
            if (tab[t].cfg_en) cfg_write(tab[t].cfg_a, tab[t].cfg_t, tab[t].cfg_c);
            run_sweep(tab[t].l0, tab[t].l1, tab[t].l2, tab[t].l3, tab[t].spk,
                      tab[t].dv, tab[t].du, t, tab[t].exp_cyc, tab[t].exp_nspk,
                      1'b0, 0, 4'd0, 8'd0);
        end

        // Config write aimed at the neuron currently in flight
        run_sweep(0, 3, 0, 0, 4'b0100, 18'h00100, 18'h3FFFF, 1, -1, -1,
                  1'b1, 1, 4'd6, 8'hF0);

        // Second tick two cycles after the first: dropped, overrun sticks
        for (int i = 0; i < 16; i++) lat_cfg[i] = 0;
        spk_cfg = '0; dv_cfg = 18'd5; du_cfg = 18'd3;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        n_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (sweep_done) n_done++;
        end
        check("overrun_single_sweep", n_done, 1);
        for (int j = 0; j < N; j++) begin
            m_v[j] = m_v[j] + 18'd5;
            m_u[j] = m_u[j] + 18'd3;
        end
        m_ovr = 1'b1;
        check("overrun_set", overrun, 1);
        check_mon_all("ovr");

        for (int r = 0; r < 6; r++) begin
            repeat (int'($urandom_range(1, 3)))
                cfg_write(int'($urandom_range(0, N - 1)), 4'($urandom), 8'($urandom));
            run_sweep(rand_lat(), rand_lat(), rand_lat(), rand_lat(), 4'($urandom),
                      18'($urandom), 18'($urandom), int'($urandom_range(0, N - 1)),
                      -1, -1, 1'b0, 0, 4'd0, 8'd0);
        end

        // Reset while neuron 2 waits on the datapath
        lat_cfg[0] = 0; lat_cfg[1] = 0; lat_cfg[2] = 40; lat_cfg[3] = 0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        k = 0; wr = 0; prev = 1'b0;
        while (!(wr == 2 && dp_if.dp_req) && k < 100) begin
            if (prev && !dp_if.dp_req) wr++;
            prev = dp_if.dp_req;
            if (!(wr == 2 && dp_if.dp_req)) begin
                @(negedge clk);
                k++;
            end
        end
        check("reached_wait_n2", {31'd0, dp_if.dp_req} + wr, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dp_req", dp_if.dp_req, 0);
        check("midrst_busy", sweep_busy, 0);
        check("midrst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (sweep_done) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        check_mon_all("midrst");
        run_sweep(0, 0, 0, 0, 4'b0000, 18'd1, 18'd1, 3, 13, 0, 1'b0, 0, 4'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
